// File: rtl/syr2k_operand_sequencer.sv
// Operand sequencer for the SYR2K element datapath: walks the lower triangle of C,
// fetches A/B/C from 1-cycle synchronous memories and presents one tuple per k.
module syr2k_operand_sequencer #(
   parameter  int N  = 4,
   parameter  int DW = 32,
   localparam int AW = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] a_addr0,
   output logic [AW-1:0] a_addr1,
   output logic [AW-1:0] b_addr0,
   output logic [AW-1:0] b_addr1,
   output logic [AW-1:0] c_addr,
   output logic          mem_re,
   input  logic [DW-1:0] a_rdata0,
   input  logic [DW-1:0] a_rdata1,
   input  logic [DW-1:0] b_rdata0,
   input  logic [DW-1:0] b_rdata1,
   input  logic [DW-1:0] c_rdata,
   output logic [DW-1:0] op_x,
   output logic [DW-1:0] op_y,
   output logic [DW-1:0] op_xt,
   output logic [DW-1:0] op_yt,
   output logic [DW-1:0] op_z,
   output logic [AW-1:0] op_i,
   output logic [AW-1:0] op_j,
   output logic [AW-1:0] op_k,
   output logic          op_first,
   output logic          op_last,
   output logic          op_valid,
   input  logic          op_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_HOLD,
      S_DONE
   } state_e;

   localparam logic [AW-1:0] LAST = AW'(N - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   // Row-major linear address, formed at 32 bits before narrowing.
   function automatic logic [AW-1:0] lin_addr(input logic [AW-1:0] row,
                                              input logic [AW-1:0] col);
      logic [31:0] full;
      full = 32'(row) * 32'(N) + 32'(col);
      return full[AW-1:0];
   endfunction

   state_e        state_q, state_d;
   logic [AW-1:0] i_q, i_d;
   logic [AW-1:0] j_q, j_d;
   logic [AW-1:0] k_q, k_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          valid_q, valid_d;
   logic          load_en;
   logic          fetch_en;

   logic [AW-1:0] addr_ik_q, addr_jk_q, addr_c_q;
   logic [AW-1:0] addr_ik_n, addr_jk_n, addr_c_n;

   logic [DW-1:0] x_q, y_q, xt_q, yt_q, z_q;
   logic [AW-1:0] oi_q, oj_q, ok_q;
   logic          first_q, last_q;

   assign addr_ik_n = lin_addr(i_q, k_q);
   assign addr_jk_n = lin_addr(j_q, k_q);
   assign addr_c_n  = lin_addr(i_q, j_q);

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      valid_d  = valid_q;
      load_en  = 1'b0;
      fetch_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            fetch_en = 1'b1;
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            load_en = 1'b1;
            valid_d = 1'b1;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (valid_q && op_ready) begin
               valid_d = 1'b0;
               // Advance k fastest, then j up to the diagonal, then i.
               if (k_q != LAST) begin
                  k_d = k_q + ONE;
               end else begin
                  k_d = '0;
                  if (j_q < i_q) begin
                     j_d = j_q + ONE;
                  end else begin
                     j_d = '0;
                     i_d = i_q + ONE;
                  end
               end
               if (i_q == LAST && j_q == LAST && k_q == LAST) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
      end
   end

   // Addresses are live during FETCH and hold their last value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_ik_q <= '0;
         addr_jk_q <= '0;
         addr_c_q  <= '0;
      end else if (fetch_en) begin
         addr_ik_q <= addr_ik_n;
         addr_jk_q <= addr_jk_n;
         addr_c_q  <= addr_c_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         xt_q    <= '0;
         yt_q    <= '0;
         z_q     <= '0;
         oi_q    <= '0;
         oj_q    <= '0;
         ok_q    <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (load_en) begin
         x_q     <= a_rdata0;
         y_q     <= a_rdata1;
         xt_q    <= b_rdata0;
         yt_q    <= b_rdata1;
         z_q     <= c_rdata;
         oi_q    <= i_q;
         oj_q    <= j_q;
         ok_q    <= k_q;
         first_q <= (k_q == '0);
         last_q  <= (k_q == LAST);
      end
   end

   assign mem_re   = fetch_en;
   assign a_addr0  = fetch_en ? addr_ik_n : addr_ik_q;
   assign b_addr0  = fetch_en ? addr_ik_n : addr_ik_q;
   assign a_addr1  = fetch_en ? addr_jk_n : addr_jk_q;
   assign b_addr1  = fetch_en ? addr_jk_n : addr_jk_q;
   assign c_addr   = fetch_en ? addr_c_n  : addr_c_q;

   assign busy     = busy_q;
   assign done     = done_q;
   assign op_valid = valid_q;
   assign op_x     = x_q;
   assign op_y     = y_q;
   assign op_xt    = xt_q;
   assign op_yt    = yt_q;
   assign op_z     = z_q;
   assign op_i     = oi_q;
   assign op_j     = oj_q;
   assign op_k     = ok_q;
   assign op_first = first_q;
   assign op_last  = last_q;

endmodule
